// File: rtl/arm_shift_pkg.sv
// arm_shift_pkg: shared shift-type, state encodings and count clamp for the iterative ARM shifter
package arm_shift_pkg;
  typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} sh_type_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
  localparam int MAX_CNT = 33;
endpackage

// File: rtl/arm_shift_step.sv
// arm_shift_step: one-bit LSL/LSR/ASR/ROR step returning the shifted word and the bit shifted out
module arm_shift_step
  import arm_shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        shtype,
  output logic [DATA_W-1:0] next_data,
  output logic              next_carry
);
  always_comb begin
    next_data = shtype == SH_LSL ? {data[DATA_W-2:0], 1'b0} :
                shtype == SH_LSR ? {1'b0, data[DATA_W-1:1]} :
                shtype == SH_ASR ? {data[DATA_W-1], data[DATA_W-1:1]} :
                                   {data[0], data[DATA_W-1:1]};
    next_carry = shtype == SH_LSL ? data[DATA_W-1] : data[0];
  end
endmodule

// File: rtl/arm_iter_shifter.sv
// arm_iter_shifter: multi-cycle ARM operand-2 shifter, one bit per clock with ARM carry-out semantics
module arm_iter_shifter
  import arm_shift_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [7:0]        shamt,
  input  logic [1:0]        shtype,
  input  logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_out
);
  state_e            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_load;
  logic [1:0]        op;
  logic [DATA_W-1:0] step_data;
  logic              step_carry;
  logic              accept;
  arm_shift_step #(.DATA_W(DATA_W)) u_step (
    .data       (result),
    .shtype     (op),
    .next_data  (step_data),
    .next_carry (step_carry)
  );
  // Clamped counts make the iterative loop land on ARM's >=32 results without special cases
  always_comb begin
    accept   = state == ST_IDLE && start;
    cnt_load = shtype == SH_ROR
             ? ((shamt != 8'd0 && shamt[4:0] == 5'd0) ? CNT_W'(32) : CNT_W'(shamt[4:0]))
             : ((shamt > 8'(MAX_CNT)) ? CNT_W'(MAX_CNT) : CNT_W'(shamt));
    state_next = state == ST_IDLE  ? (start ? (cnt_load != '0 ? ST_SHIFT : ST_DONE) : ST_IDLE) :
                 state == ST_SHIFT ? (cnt == CNT_W'(1) ? ST_DONE : ST_SHIFT) :
                                     ST_IDLE;
    busy = state != ST_IDLE;
    done = state == ST_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      cnt       <= '0;
      op        <= 2'd0;
    end else if (accept) begin
      result    <= data_in;
      carry_out <= carry_in;
      cnt       <= cnt_load;
      op        <= shtype;
    end else if (state == ST_SHIFT) begin
      result    <= step_data;
      carry_out <= step_carry;
      cnt       <= cnt - CNT_W'(1);
    end
endmodule

// File: tb/tb_arm_iter_shifter.sv
// tb_arm_iter_shifter: directed checks of shift results, carries, latency, ignored starts and async reset
module tb_arm_iter_shifter;
  import arm_shift_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  shamt = '0;
  logic [1:0]  shtype = '0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] result;
  int tests = 0;
  int fails = 0;

  arm_iter_shifter dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .shamt(shamt),
    .shtype(shtype), .carry_in(carry_in), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] d, input logic [7:0] sa,
                     input logic [1:0] t, input logic c, input logic [31:0] er,
                     input logic ec, input int ecyc);
    int n;
    @(negedge clk);
    data_in = d; shamt = sa; shtype = t; carry_in = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_in = ~d; shamt = 8'hFF; shtype = ~t; carry_in = ~c;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, ecyc);
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, {31'd0, carry_out}, {31'd0, ec});
    start = 1'b1; data_in = 32'h1234_5678; shamt = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " idle after done"}, {31'd0, busy}, 32'd0);
    chk({tag, " result held"}, result, er);
  endtask

  initial begin
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run("lsl1",   32'h8000_0001, 8'd1,   SH_LSL, 1'b0, 32'h0000_0002, 1'b1, 1);
    run("lsr32",  32'h8000_0000, 8'd32,  SH_LSR, 1'b0, 32'h0000_0000, 1'b1, 32);
    run("lsl200", 32'h8000_0000, 8'd200, SH_LSL, 1'b1, 32'h0000_0000, 1'b0, 33);
    run("lsl32",  32'h0000_0001, 8'd32,  SH_LSL, 1'b0, 32'h0000_0000, 1'b1, 32);
    run("asr4",   32'hF000_0000, 8'd4,   SH_ASR, 1'b1, 32'hFF00_0000, 1'b0, 4);
    run("asr40",  32'h8000_0000, 8'd40,  SH_ASR, 1'b0, 32'hFFFF_FFFF, 1'b1, 33);
    run("ror4",   32'h0000_00F1, 8'd4,   SH_ROR, 1'b1, 32'h1000_000F, 1'b0, 4);
    run("ror64",  32'h8000_0000, 8'd64,  SH_ROR, 1'b0, 32'h8000_0000, 1'b1, 32);
    run("ror36",  32'h0000_00F1, 8'd36,  SH_ROR, 1'b1, 32'h1000_000F, 1'b0, 4);
    run("zero",   32'hDEAD_BEEF, 8'd0,   SH_LSR, 1'b1, 32'hDEAD_BEEF, 1'b1, 0);

    // Second start mid-shift must not disturb the operation in flight
    @(negedge clk);
    data_in = 32'h0000_0001; shamt = 8'd10; shtype = SH_LSL; carry_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy", {31'd0, busy}, 32'd1);
    data_in = 32'hFFFF_FFFF; shamt = 8'd1; shtype = SH_ROR; start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("mid latency", n, 6);
    end
    chk("mid result", result, 32'h0000_0400);
    chk("mid carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);

    // Asynchronous reset during an LSL 20
    data_in = 32'h0000_0001; shamt = 8'd20; shtype = SH_LSL; carry_in = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset result", result, 32'h0000_0020);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk); rst = 1'b0;
    run("post-rst lsl3", 32'h0000_0001, 8'd3, SH_LSL, 1'b1, 32'h0000_0008, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
